comp_job_sched: RTL
===================

# comp_job_sched

Round-robin job scheduler that shares the single HACD page compressor between `NUM_REQ` requesters. It arbitrates compression requests, drives the compressor's `comp_start` level and page base, and waits for `comp_done` or `incompressible`, with a watchdog timeout. It returns a one-hot result (status and size) to the granted requester. It sits between the HACD page-migration/eviction agents and the compressor.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 40, page base address width
- TIMEOUT_CYCLES, 4096, max cycles in RUN before abort (≥16)
- RELEASE_CYCLES, 2, cycles `comp_start_o` is held low between jobs (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester job request (level, held until accepted)
- req_page_i  in  NUM_REQ*ADDR_W  page base per requester; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_ready_o  out  NUM_REQ  one-hot accept pulse, 1 cycle
- rsp_valid_o  out  NUM_REQ  one-hot result pulse, 1 cycle
- rsp_status_o  out  2  0 = compressed, 1 = incompressible, 2 = timeout; valid with rsp_valid_o
- rsp_size_o  out  14  result size in bytes; valid with rsp_valid_o
- comp_start_o  out  1  level start to compressor
- comp_page_o  out  ADDR_W  page base of current job, stable while comp_start_o=1
- comp_done_i  in  1  compressor completion
- incompressible_i  in  1  compressor incompressible pulse
- comp_size_i  in  14  compressor size, sampled with comp_done_i
- busy_o  out  1  state ≠ IDLE
- grant_idx_o  out  clog2(NUM_REQ)  index of the current/last granted requester

## Operation
- States: IDLE, RUN, REPORT, RELEASE.
- IDLE: if any req_valid_i is set, select winner w by round-robin, starting the search at (grant_idx_o+1) mod NUM_REQ. Next cycle:
  - state=RUN, req_ready_o[w]=1 (one cycle)
  - comp_start_o=1, comp_page_o=page[w], grant_idx_o=w
  - watchdog counter=0
- RUN:
  - comp_start_o held 1; counter increments each cycle.
  - incompressible_i=1 → status 1, size 14'd4096 (64 lines × 64 B).
  - else comp_done_i=1 → status 0, size comp_size_i.
  - else counter==TIMEOUT_CYCLES-1 → status 2, size 0.
  - Any of the three → REPORT.
- REPORT (1 cycle): rsp_valid_o[grant_idx_o]=1 with registered status/size; comp_start_o=0; → RELEASE.
- RELEASE: comp_start_o=0 for RELEASE_CYCLES cycles so the compressor leaves DONE and returns to IDLE; then → IDLE.
- Requests are never dropped. A requester whose req_valid_i falls before grant is simply not considered. req_valid_i changes during RUN have no effect on the current job.
- The grant pointer advances only on grant. After reset grant_idx_o=NUM_REQ-1, so requester 0 has first priority.

## Timing
- Reset (async, any state): state=IDLE; req_ready_o=0, rsp_valid_o=0, rsp_status_o=0, rsp_size_o=0, comp_start_o=0, comp_page_o=0, busy_o=0, grant_idx_o=NUM_REQ-1, counter=0.
- Reset mid-job aborts the job with no response. The compressor is reset by the same rst_ni.
- All outputs are registered.
- Request visible at edge t (IDLE) → req_ready_o and comp_start_o high after edge t+1.
- Completion input seen at edge t (RUN) → rsp_valid_o high after edge t+1; comp_start_o low from the same edge.
- Minimum job-to-job spacing: 1 (grant) + compressor latency + 1 (REPORT) + RELEASE_CYCLES.
- Simultaneous incompressible_i and comp_done_i: incompressible wins.
- Completion on the same cycle as the timeout terminal count: the completion wins.
- comp_done_i/incompressible_i outside RUN are ignored.
- Counter is $clog2(TIMEOUT_CYCLES) bits wide and never wraps (leaves RUN at terminal count).

## Test plan
- Single request: req_valid_i=4'b0100, page 0x1000 → req_ready_o=4'b0100 one cycle later, comp_page_o=0x1000; comp_done_i with comp_size_i=1088 → rsp_valid_o=4'b0100, status 0, size 1088; comp_start_o low 2 cycles before IDLE.
- Round-robin: all four requesting continuously, each job done after 10 cycles → grant order 0,1,2,3,0; no requester granted twice before the others.
- Incompressible: incompressible_i pulse in RUN → status 1, size 4096. Both inputs on the same cycle → status 1.
- Timeout: TIMEOUT_CYCLES=16, no completion → rsp_valid_o exactly 17 cycles after req_ready_o, status 2, size 0. comp_done_i on count 15 → status 0.
- Reset mid-RUN: assert rst_ni=0 at RUN cycle 5 → all outputs at reset values immediately, no rsp_valid_o; after release, the pending request is granted to requester 0 first.
- Spurious inputs: comp_done_i pulses in IDLE/RELEASE → no response, no state change.

Source files
------------

// File: rtl/comp_job_sched.sv
// Round-robin scheduler sharing one page compressor between NUM_REQ requesters.
// Grants a job, holds comp_start_o through RUN, reports a one-hot result, then releases.
module comp_job_sched #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 40,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_page_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   output logic [1:0]                  rsp_status_o,
   output logic [13:0]                 rsp_size_o,
   output logic                        comp_start_o,
   output logic [ADDR_W-1:0]           comp_page_o,
   input  logic                        comp_done_i,
   input  logic                        incompressible_i,
   input  logic [13:0]                 comp_size_i,
   output logic                        busy_o,
   output logic [$clog2(NUM_REQ)-1:0]  grant_idx_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_REPORT  = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   state_e              state_q;
   logic [NUM_REQ-1:0]  req_ready_q;
   logic [NUM_REQ-1:0]  rsp_valid_q;
   logic [1:0]          rsp_status_q;
   logic [13:0]         rsp_size_q;
   logic                comp_start_q;
   logic [ADDR_W-1:0]   comp_page_q;
   logic                busy_q;
   logic [IDX_W-1:0]    grant_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [REL_W-1:0]    rel_q;

   logic                any_d;
   logic [IDX_W-1:0]    win_d;
   logic [IDX_W-1:0]    idx;
   logic [NUM_REQ-1:0]  win_oh;
   logic [NUM_REQ-1:0]  grant_oh;
   logic [ADDR_W-1:0]   win_page;

   // Search starts one past the last grant, so the last winner has lowest priority.
   always_comb begin
      any_d = 1'b0;
      win_d = grant_q;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(grant_q) + k) % NUM_REQ);
         if (!any_d && req_valid_i[idx]) begin
            any_d = 1'b1;
            win_d = idx;
         end
      end
   end

   assign win_oh   = NUM_REQ'(1) << win_d;
   assign grant_oh = NUM_REQ'(1) << grant_q;
   assign win_page = req_page_i[int'(win_d)*ADDR_W +: ADDR_W];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         req_ready_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_status_q <= 2'd0;
         rsp_size_q   <= 14'd0;
         comp_start_q <= 1'b0;
         comp_page_q  <= '0;
         busy_q       <= 1'b0;
         grant_q      <= IDX_W'(NUM_REQ - 1);
         cnt_q        <= '0;
         rel_q        <= '0;
      end else begin
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (any_d) begin
                  state_q      <= S_RUN;
                  req_ready_q  <= win_oh;
                  comp_start_q <= 1'b1;
                  comp_page_q  <= win_page;
                  grant_q      <= win_d;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
               end
            end
            S_RUN: begin
               // Priority: incompressible, then done, then the watchdog.
               if (incompressible_i) begin
                  rsp_status_q <= 2'd1;
                  rsp_size_q   <= 14'd4096;
                  state_q      <= S_REPORT;
               end else if (comp_done_i) begin
                  rsp_status_q <= 2'd0;
                  rsp_size_q   <= comp_size_i;
                  state_q      <= S_REPORT;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_status_q <= 2'd2;
                  rsp_size_q   <= 14'd0;
                  state_q      <= S_REPORT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_REPORT: begin
               rsp_valid_q  <= grant_oh;
               comp_start_q <= 1'b0;
               rel_q        <= '0;
               state_q      <= S_RELEASE;
            end
            S_RELEASE: begin
               if (rel_q == REL_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rel_q <= rel_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_status_o = rsp_status_q;
   assign rsp_size_o   = rsp_size_q;
   assign comp_start_o = comp_start_q;
   assign comp_page_o  = comp_page_q;
   assign busy_o       = busy_q;
   assign grant_idx_o  = grant_q;

endmodule
